// File: rtl/sum_rank_sorter.sv
// Register-based insertion sorter: ranks one final pixel sum per image and drains (id, sum) pairs.
// Define SUM_RANK_ASCEND_EN for ascending (darkest first) ranking; descending by default.
module sum_rank_sorter #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 3,
  parameter int SUM_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             in_ready,
  input  logic             rd_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_last,
  output logic [ID_W:0]    count,
  output logic             full,
  output logic             busy,
  output logic             dropped
);

  typedef enum logic {S_FILL, S_DRAIN} state_e;

  localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q [DEPTH];
  logic [SUM_W-1:0] sum_d [DEPTH];
  logic [ID_W-1:0]  id_q  [DEPTH];
  logic [ID_W-1:0]  id_d  [DEPTH];
  logic [ID_W:0]    count_q, count_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             dropped_q, dropped_d;
  logic             out_valid_q, out_valid_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;

  logic             insert;
  logic [DEPTH-1:0] place;

  assign in_ready  = (state_q == S_FILL) && (count_q < DEPTH_C);
  assign insert    = sum_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign busy      = (state_q == S_DRAIN);
  assign dropped   = dropped_q;

  // Empty slots count as "worse", so place[] is a thermometer starting at the insertion slot.
  always_comb begin
    place = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SUM_RANK_ASCEND_EN
      place[i] = ((ID_W+1)'(i) >= count_q) || (sum_q[i] > sum_in);
`else
      place[i] = ((ID_W+1)'(i) >= count_q) || (sum_q[i] < sum_in);
`endif
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    id_d        = id_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    dropped_d   = dropped_q | (sum_valid & ~in_ready);
    out_valid_d = 1'b0;
    out_id_d    = '0;
    out_sum_d   = '0;
    out_last_d  = 1'b0;

    if (clr) begin
      state_d   = S_FILL;
      count_d   = '0;
      ptr_d     = '0;
      dropped_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        sum_d[i] = '0;
        id_d[i]  = '0;
      end
    end else begin
      case (state_q)
        S_FILL: begin
          if (insert) begin
            if (place[0]) begin
              sum_d[0] = sum_in;
              id_d[0]  = count_q[ID_W-1:0];
            end
            for (int i = 1; i < DEPTH; i++) begin
              if (place[i] && place[i-1]) begin
                sum_d[i] = sum_q[i-1];
                id_d[i]  = id_q[i-1];
              end else if (place[i]) begin
                sum_d[i] = sum_in;
                id_d[i]  = count_q[ID_W-1:0];
              end
            end
            count_d = count_q + 1'b1;
          end
          if (rd_start && (count_q != '0)) begin
            state_d = S_DRAIN;
            ptr_d   = '0;
          end
        end
        S_DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_d = S_FILL;
              count_d = '0;
              ptr_d   = '0;
              for (int i = 0; i < DEPTH; i++) begin
                sum_d[i] = '0;
                id_d[i]  = '0;
              end
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end

    // Registered outputs are looked up from next-state so they appear the cycle after the edge.
    if (state_d == S_DRAIN) begin
      out_valid_d = 1'b1;
      out_id_d    = id_d[ptr_d];
      out_sum_d   = sum_d[ptr_d];
      out_last_d  = ({1'b0, ptr_d} == (count_d - 1'b1));
    end
  end

  // NOTE: the slot array is reset explicitly because reset must leave every slot at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FILL;
      count_q     <= '0;
      ptr_q       <= '0;
      dropped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        sum_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking updates keep every register sampling the pre-edge values.
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      dropped_q   <= dropped_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
    end
  end

endmodule

// File: tb/tb_sum_rank_sorter.sv
// Randomized scoreboard bench for sum_rank_sorter; the reference ranks each batch by stable selection.
module tb_sum_rank_sorter;

  localparam int DEPTH = 8;
  localparam int ID_W  = 3;
  localparam int SUM_W = 22;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [SUM_W-1:0] sum;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic [SUM_W-1:0] sum_in;
  logic             sum_valid;
  logic             in_ready;
  logic             rd_start;
  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic [SUM_W-1:0] out_sum;
  logic             out_last;
  logic [ID_W:0]    count;
  logic             full;
  logic             busy;
  logic             dropped;

  sum_rank_sorter #(.DEPTH(DEPTH), .ID_W(ID_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
    .in_ready(in_ready), .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_sum(out_sum), .out_last(out_last), .count(count), .full(full),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t batch[$];
  ent_t exp_q[$];
  bit   dropped_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit better(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
`ifdef SUM_RANK_ASCEND_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  // Stable selection: earliest arrival wins among equal sums.
  function automatic void push_ranked();
    ent_t pool[$];
    int   b;
    pool = batch;
    while (pool.size() > 0) begin
      b = 0;
      for (int i = 1; i < pool.size(); i++)
        if (better(pool[i].sum, pool[b].sum)) b = i;
      exp_q.push_back(pool[b]);
      pool.delete(b);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input logic sv, input logic [SUM_W-1:0] s, input logic rs, input logic cl);
    int cnt0;
    cnt0 = batch.size();
    sum_valid = sv; sum_in = s; rd_start = rs; clr = cl;
    if (cl) begin
      batch.delete();
      dropped_m = 1'b0;
    end else begin
      if (sv) begin
        if (cnt0 < DEPTH) batch.push_back('{ID_W'(cnt0), s});
        else dropped_m = 1'b1;
      end
      if (rs && cnt0 > 0) begin
        push_ranked();
        batch.delete();
      end
    end
    tick();
    sum_valid = 1'b0; rd_start = 1'b0; clr = 1'b0;
  endtask

  task automatic check_fill();
    check("count", 32'(count), 32'(batch.size()));
    check("full", 32'(full), 32'(batch.size() == DEPTH));
    check("in_ready", 32'(in_ready), 32'(batch.size() < DEPTH));
    check("dropped", 32'(dropped), 32'(dropped_m));
    check("busy_fill", 32'(busy), 32'd0);
  endtask

  // mode 0: ready always, 1: pattern 1,0,0,1, else random.
  task automatic drain_wait(input int mode);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((i % 4) == 0) || ((i % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    out_ready = 1'b1;
    check("drain_done", 32'(done), 32'd1);
    check("count_after_drain", 32'(count), 32'd0);
  endtask

  function automatic logic [SUM_W-1:0] rand_sum();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return {SUM_W{1'b1}};
      2:       return SUM_W'($urandom_range(0, 7) * 100);
      default: return SUM_W'($urandom());
    endcase
  endfunction

  // Monitor: pops the scoreboard on every accepted transfer and checks stall stability.
  bit               stall_prev = 1'b0;
  logic [ID_W-1:0]  held_id;
  logic [SUM_W-1:0] held_sum;
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
      end else if (out_valid) begin
        if (stall_prev) begin
          check("stall_id_stable", 32'(out_id), 32'(held_id));
          check("stall_sum_stable", 32'(out_sum), 32'(held_sum));
        end
        if (out_ready) begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_id", 32'(out_id), 32'(e.id));
            check("out_sum", 32'(out_sum), 32'(e.sum));
            check("out_last", 32'(out_last), 32'(exp_q.size() == 0));
          end
        end else begin
          stall_prev = 1'b1;
          held_id    = out_id;
          held_sum   = out_sum;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit do_ins;
    int n;
    reset = 1'b0; clr = 1'b0; sum_in = '0; sum_valid = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    tick();

    // Basic ranking with a tie.
    do_cycle(1, 22'd100, 0, 0);
    do_cycle(1, 22'd500, 0, 0);
    do_cycle(1, 22'd300, 0, 0);
    do_cycle(1, 22'd500, 0, 0);
    check_fill();
    do_cycle(0, '0, 1, 0);
    drain_wait(0);

    // Overflow sets dropped; clr clears it.
    for (int i = 0; i < DEPTH; i++) do_cycle(1, SUM_W'((i * 37) % 11), 0, 0);
    check_fill();
    do_cycle(1, 22'd999, 0, 0);
    check_fill();
    do_cycle(0, '0, 0, 1);
    check_fill();

    // Stalled drain with ready pattern 1,0,0,1.
    do_cycle(1, 22'd10, 0, 0);
    do_cycle(1, 22'd30, 0, 0);
    do_cycle(1, 22'd20, 0, 0);
    do_cycle(0, '0, 1, 0);
    drain_wait(1);

    // Same-cycle insert and rd_start.
    do_cycle(1, 22'd200, 0, 0);
    do_cycle(1, 22'd400, 0, 0);
    do_cycle(1, 22'd700, 1, 0);
    drain_wait(0);

    // Reset mid-drain after two transfers.
    for (int i = 0; i < 5; i++) do_cycle(1, SUM_W'(i * 10 + 5), 0, 0);
    out_ready = 1'b1;
    do_cycle(0, '0, 1, 0);
    tick(); tick();
    check("pre_reset_remaining", 32'(exp_q.size()), 32'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_id", 32'(out_id), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    batch.delete();
    dropped_m = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_cycle(1, 22'd50, 0, 0);
    do_cycle(0, '0, 1, 0);
    drain_wait(0);

    // Randomized batches.
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) do_cycle(0, '0, 0, 0);
        if ($urandom_range(0, 15) == 0) do_cycle(0, '0, 0, 1);
        do_cycle(1, rand_sum(), 0, 0);
      end
      check_fill();
      do_ins = ($urandom_range(0, 1) == 1) && (batch.size() > 0);
      do_cycle(do_ins, rand_sum(), 1, 0);
      if (exp_q.size() > 0) drain_wait(2);
      else check("busy_ignored_rd", 32'(busy), 32'd0);
      if ($urandom_range(0, 2) == 0) do_cycle(0, '0, 0, 1);
      check_fill();
    end

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
